calc_cmd_sequencer: RTL and testbench



---
 rtl/calc_cmd_sequencer.sv | 130 +++++++++++++
 tb/tb_calc_cmd_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_cmd_sequencer.sv
// Byte-stream command sequencer for the calculator ALU.
// Assembles 5-byte commands, drives the ALU, returns 5-byte responses.
module calc_cmd_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int RX_TIMEOUT    = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] alu_p,
  output logic [15:0] alu_q,
  output logic [3:0]  alu_opcode,
  input  logic [31:0] alu_result,
  input  logic [1:0]  alu_error,
  output logic        busy,
  output logic        frame_err
);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_BODY,
    WAIT,
    TX
  } state_t;

  localparam int IW = $clog2(RX_TIMEOUT + 1);

  state_t        state;
  logic [2:0]    cnt;
  logic [3:0]    settle;
  logic [IW-1:0] idle;
  logic [3:0]    op_sh;
  logic [15:0]   p_sh;
  logic [7:0]    qh_sh;
  logic [39:0]   resp;
  logic [2:0]    tx_idx;
  logic          illegal;

  assign illegal   = alu_opcode > 4'd4;
  assign in_ready  = (state == RX_IDLE) || (state == RX_BODY);
  assign busy      = state != RX_IDLE;
  assign out_valid = state == TX;
  assign out_data  = (state == TX) ? resp[39:32] : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      settle     <= '0;
      idle       <= '0;
      op_sh      <= '0;
      p_sh       <= '0;
      qh_sh      <= '0;
      resp       <= '0;
      tx_idx     <= '0;
      alu_p      <= '0;
      alu_q      <= '0;
      alu_opcode <= '0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      unique case (state)
        RX_IDLE: begin
          if (in_valid) begin
            op_sh <= in_data[3:0];
            cnt   <= 3'd1;
            idle  <= '0;
            state <= RX_BODY;
          end
        end
        RX_BODY: begin
          if (in_valid) begin
            idle <= '0;
            cnt  <= cnt + 3'd1;
            unique case (cnt)
              3'd1: p_sh[15:8] <= in_data;
              3'd2: p_sh[7:0]  <= in_data;
              3'd3: qh_sh      <= in_data;
              default: begin
                alu_p      <= p_sh;
                alu_q      <= {qh_sh, in_data};
                alu_opcode <= op_sh;
                settle     <= 4'(SETTLE_CYCLES);
                cnt        <= '0;
                state      <= WAIT;
              end
            endcase
          end else if (idle == IW'(RX_TIMEOUT - 1)) begin
            // partial frame dropped; ALU operands keep their last values
            idle      <= '0;
            cnt       <= '0;
            frame_err <= 1'b1;
            state     <= RX_IDLE;
          end else begin
            idle <= idle + 1'b1;
          end
        end
        WAIT: begin
          if (settle == 4'd1) begin
            resp <= {5'b0, illegal,
                     illegal ? 2'b00 : alu_error,
                     illegal ? 32'h0 : alu_result};
            settle <= '0;
            tx_idx <= '0;
            state  <= TX;
          end else begin
            settle <= settle - 4'd1;
          end
        end
        TX: begin
          if (out_ready) begin
            resp <= {resp[31:0], 8'h00};
            if (tx_idx == 3'd4) begin
              tx_idx <= '0;
              state  <= RX_IDLE;
            end else begin
              tx_idx <= tx_idx + 3'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Directed bench for calc_cmd_sequencer.
// Expected response bytes are queued at stimulus time and popped on output.
module tb_calc_cmd_sequencer;

  localparam int SETTLE = 2;
  localparam int TMO    = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] alu_p;
  logic [15:0] alu_q;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_result;
  logic [1:0]  alu_error;
  logic        busy;
  logic        frame_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  calc_cmd_sequencer #(
    .SETTLE_CYCLES(SETTLE),
    .RX_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_p(alu_p),
    .alu_q(alu_q),
    .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .alu_error(alu_error),
    .busy(busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // behavioural ALU; illegal opcodes return junk that must be masked
  always_comb begin
    alu_result = 32'h0;
    alu_error  = 2'b00;
    case (alu_opcode)
      4'd0: alu_result = {16'h0, alu_p} * {16'h0, alu_q};
      4'd1: if (alu_q == 0) alu_error = 2'b01;
            else alu_result = {16'h0, alu_p / alu_q};
      4'd2: if (alu_q == 0) alu_error = 2'b01;
            else alu_result = {16'h0, alu_p % alu_q};
      4'd3: alu_result = {16'h0, alu_p} - {16'h0, alu_q};
      4'd4: alu_result = {16'h0, alu_p} + {16'h0, alu_q};
      default: begin
        alu_result = 32'hDEADBEEF;
        alu_error  = 2'b10;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("send_timeout", 1, 0);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int i = 0; i < 5; i++) send_byte(f[39-8*i -: 8]);
  endtask

  task automatic push_exp(input logic [39:0] r);
    for (int i = 0; i < 5; i++) exp_q.push_back(r[39-8*i -: 8]);
  endtask

  task automatic recv_byte(input int stall);
    logic [7:0] held;
    logic [7:0] e;
    int n;
    n = 0;
    out_ready = 1'b0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("out_valid_timeout", 1, 0);
    held = out_data;
    for (int k = 0; k < stall; k++) begin
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, held);
    end
    chk("in_ready_tx", in_ready, 0);
    e = exp_q.pop_front();
    chk("resp_byte", out_data, e);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic recv_frame(input int stall_max);
    for (int i = 0; i < 5; i++) recv_byte($urandom_range(0, stall_max));
    chk("in_ready_after", in_ready, 1);
    chk("out_valid_after", out_valid, 0);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int fe_cnt;
    int fe_at;
    logic [35:0] alu_snap;

    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_alu", {alu_p, alu_q, alu_opcode}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    #20 rst_n = 1'b1;
    tick();

    // subtract, latency check
    send_frame(40'h03_00_1F_00_03);
    push_exp(40'h00_00_00_00_1C);
    chk("sub_alu", {alu_opcode, alu_p, alu_q}, {4'd3, 16'h001F, 16'h0003});
    chk("lat_e", out_valid, 0);
    tick();
    chk("lat_e1", out_valid, 0);
    tick();
    chk("lat_e2", out_valid, 1);
    recv_frame(0);

    // multiply with random stalls
    send_frame(40'h00_FF_FF_FF_FF);
    push_exp(40'h00_FF_FE_00_01);
    recv_frame(5);

    // divide by zero; in_ready low through WAIT and TX
    send_frame(40'h01_00_07_00_00);
    push_exp(40'h01_00_00_00_00);
    chk("div0_in_ready_e", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    tick();
    chk("div0_in_ready_wait", in_ready, 0);
    chk("div0_busy", busy, 1);
    in_valid = 1'b0;
    recv_frame(2);

    // illegal opcode: ALU still driven, result masked
    send_frame(40'h07_12_34_56_78);
    push_exp(40'h04_00_00_00_00);
    chk("ill_alu", {alu_opcode, alu_p, alu_q}, {4'd7, 16'h1234, 16'h5678});
    recv_frame(1);

    // timeout after partial frame
    alu_snap = {alu_opcode, alu_p, alu_q};
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h10);
    fe_cnt = 0;
    fe_at  = 0;
    for (int c = 1; c <= TMO + 5; c++) begin
      tick();
      if (frame_err) begin
        fe_cnt++;
        if (fe_at == 0) fe_at = c;
      end
    end
    chk("tmo_pulses", fe_cnt, 1);
    chk("tmo_cycle", fe_at, TMO);
    chk("tmo_busy", busy, 0);
    chk("tmo_in_ready", in_ready, 1);
    chk("tmo_alu", {alu_opcode, alu_p, alu_q}, alu_snap);

    // byte arriving on the timeout edge wins
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    fe_cnt = 0;
    for (int c = 1; c < TMO; c++) begin
      tick();
      if (frame_err) fe_cnt++;
    end
    send_byte(8'h02);
    if (frame_err) fe_cnt++;
    push_exp(40'h00_00_00_00_03);
    chk("race_no_err", fe_cnt, 0);
    chk("race_alu", {alu_opcode, alu_p, alu_q}, {4'd4, 16'h0001, 16'h0002});
    recv_frame(0);

    // reset during TX of byte 2
    send_frame(40'h03_00_1F_00_03);
    push_exp(40'h00_00_00_00_1C);
    recv_byte(0);
    recv_byte(1);
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_tx_valid", out_valid, 0);
    chk("rst_tx_in_ready", in_ready, 1);
    chk("rst_tx_busy", busy, 0);
    exp_q.delete();
    #12 rst_n = 1'b1;
    tick();
    chk("post_rst_valid", out_valid, 0);
    send_frame(40'h04_00_05_00_05);
    push_exp(40'h00_00_00_00_0A);
    recv_frame(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
